// File: rtl/axi_ram_slave.sv
// axi_ram_slave: AXI4 responder backed by a dual-port word RAM.
// Define AXI_RAM_WRAP_EN to honour WRAP bursts; otherwise WRAP acts as INCR.
module axi_ram_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h1C00_0000,
  parameter int          MEM_WORDS = 65536,
  parameter string       INIT_FILE = ""
) (
  input  logic        s_aclk,
  input  logic        s_aresetn,
  input  logic [31:0] s_axi_araddr,
  input  logic [7:0]  s_axi_arlen,
  input  logic [2:0]  s_axi_arsize,
  input  logic [1:0]  s_axi_arburst,
  input  logic [3:0]  s_axi_arid,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic [3:0]  s_axi_rid,
  output logic        s_axi_rlast,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  input  logic [31:0] s_axi_awaddr,
  input  logic [7:0]  s_axi_awlen,
  input  logic [2:0]  s_axi_awsize,
  input  logic [1:0]  s_axi_awburst,
  input  logic [3:0]  s_axi_awid,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wlast,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic [3:0]  s_axi_bid,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [32:0] LIMIT = 33'(MEM_WORDS) << 2;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic {R_IDLE, R_BURST} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  logic [31:0] mem [MEM_WORDS];

  r_state_t    r_state;
  logic [31:0] r_addr, r_next;
  logic [7:0]  r_len, r_cnt;
  logic [2:0]  r_size;
  logic [1:0]  r_burst;

  w_state_t    w_state;
  logic [31:0] w_addr, w_next;
  logic [7:0]  w_len, w_cnt;
  logic [2:0]  w_size;
  logic [1:0]  w_burst;
  logic        w_err;

  logic        ar_bad, r_bad, w_bad;
  logic [31:0] f_addr, f_off, w_off;
  logic        f_bad, f_ok, w_ok, w_fire, w_last, w_err_beat;
  logic [AW-1:0] f_idx, w_idx;

`ifdef AXI_RAM_WRAP_EN
  logic [31:0] r_mask, w_mask;

  function automatic logic wrap_bad(input logic [1:0] b, input logic [7:0] l);
    return (b == 2'b10) &&
           !(l == 8'd1 || l == 8'd3 || l == 8'd7 || l == 8'd15);
  endfunction

  assign ar_bad = wrap_bad(s_axi_arburst, s_axi_arlen);
  assign r_bad  = wrap_bad(r_burst, r_len);
  assign w_bad  = wrap_bad(w_burst, w_len);
`else
  assign ar_bad = 1'b0;
  assign r_bad  = 1'b0;
  assign w_bad  = 1'b0;
`endif

  // next read beat address: FIXED holds, WRAP folds inside its window
  always_comb begin
    r_next = (r_burst == 2'b00) ? r_addr : r_addr + (32'd1 << r_size);
`ifdef AXI_RAM_WRAP_EN
    r_mask = ((32'(r_len) + 32'd1) << r_size) - 32'd1;
    if (r_burst == 2'b10)
      r_next = (r_addr & ~r_mask) | ((r_addr + (32'd1 << r_size)) & r_mask);
`endif
  end

  // next write beat address, same rules as the read side
  always_comb begin
    w_next = (w_burst == 2'b00) ? w_addr : w_addr + (32'd1 << w_size);
`ifdef AXI_RAM_WRAP_EN
    w_mask = ((32'(w_len) + 32'd1) << w_size) - 32'd1;
    if (w_burst == 2'b10)
      w_next = (w_addr & ~w_mask) | ((w_addr + (32'd1 << w_size)) & w_mask);
`endif
  end

  assign f_addr = (r_state == R_IDLE) ? s_axi_araddr : r_next;
  assign f_bad  = (r_state == R_IDLE) ? ar_bad : r_bad;
  assign f_off  = f_addr - BASE_ADDR;
  assign f_ok   = ({1'b0, f_off} < LIMIT) && !f_bad;
  assign f_idx  = f_off[AW+1:2];

  assign w_off  = w_addr - BASE_ADDR;
  assign w_ok   = ({1'b0, w_off} < LIMIT) && !w_bad;
  assign w_idx  = w_off[AW+1:2];
  assign w_fire = (w_state == W_DATA) && s_axi_wvalid && s_axi_wready;
  assign w_last = (w_cnt == w_len);
  assign w_err_beat = !w_ok || (s_axi_wlast != w_last);

  // byte-lane RAM write; out-of-range or illegal-wrap beats are dropped
  always_ff @(posedge s_aclk) begin
    if (w_fire && w_ok)
      for (int b = 0; b < 4; b++)
        if (s_axi_wstrb[b])
          mem[w_idx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
  end

  // read engine: prefetch each beat into the registered R channel
  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      r_state       <= R_IDLE;
      s_axi_arready <= 1'b1;
      s_axi_rvalid  <= 1'b0;
      s_axi_rlast   <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= OKAY;
      s_axi_rid     <= '0;
      r_addr        <= '0;
      r_len         <= '0;
      r_size        <= '0;
      r_burst       <= '0;
      r_cnt         <= '0;
    end else begin
      unique case (r_state)
        R_IDLE: begin
          if (s_axi_arvalid) begin
            r_addr        <= s_axi_araddr;
            r_len         <= s_axi_arlen;
            r_size        <= s_axi_arsize;
            r_burst       <= s_axi_arburst;
            r_cnt         <= '0;
            s_axi_rid     <= s_axi_arid;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b1;
            s_axi_rlast   <= (s_axi_arlen == 8'd0);
            s_axi_rdata   <= f_ok ? mem[f_idx] : '0;
            s_axi_rresp   <= f_ok ? OKAY : SLVERR;
            r_state       <= R_BURST;
          end
        end
        R_BURST: begin
          if (s_axi_rready) begin
            if (s_axi_rlast) begin
              s_axi_rvalid  <= 1'b0;
              s_axi_rlast   <= 1'b0;
              s_axi_arready <= 1'b1;
              r_state       <= R_IDLE;
            end else begin
              r_addr      <= r_next;
              r_cnt       <= r_cnt + 8'd1;
              s_axi_rlast <= ((r_cnt + 8'd1) == r_len);
              s_axi_rdata <= f_ok ? mem[f_idx] : '0;
              s_axi_rresp <= f_ok ? OKAY : SLVERR;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // write engine: accept AW, stream W beats, then hold B until taken
  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      w_state       <= W_IDLE;
      s_axi_awready <= 1'b1;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= OKAY;
      s_axi_bid     <= '0;
      w_addr        <= '0;
      w_len         <= '0;
      w_size        <= '0;
      w_burst       <= '0;
      w_cnt         <= '0;
      w_err         <= 1'b0;
    end else begin
      unique case (w_state)
        W_IDLE: begin
          if (s_axi_awvalid) begin
            w_addr        <= s_axi_awaddr;
            w_len         <= s_axi_awlen;
            w_size        <= s_axi_awsize;
            w_burst       <= s_axi_awburst;
            w_cnt         <= '0;
            w_err         <= 1'b0;
            s_axi_bid     <= s_axi_awid;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b1;
            w_state       <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            if (w_last) begin
              s_axi_wready <= 1'b0;
              s_axi_bvalid <= 1'b1;
              s_axi_bresp  <= (w_err || w_err_beat) ? SLVERR : OKAY;
              w_state      <= W_RESP;
            end else begin
              w_cnt  <= w_cnt + 8'd1;
              w_addr <= w_next;
              w_err  <= w_err || w_err_beat;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_ram_slave.sv
// tb_axi_ram_slave: directed bench for axi_ram_slave.
// Covers INCR/FIXED/WRAP bursts, strobes, stalls, errors and mid-burst reset.
module tb_axi_ram_slave;

  localparam logic [31:0] BASE = 32'h1C00_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] s_axi_araddr;
  logic [7:0]  s_axi_arlen;
  logic [2:0]  s_axi_arsize;
  logic [1:0]  s_axi_arburst;
  logic [3:0]  s_axi_arid;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic [3:0]  s_axi_rid;
  logic        s_axi_rlast;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic [31:0] s_axi_awaddr;
  logic [7:0]  s_axi_awlen;
  logic [2:0]  s_axi_awsize;
  logic [1:0]  s_axi_awburst;
  logic [3:0]  s_axi_awid;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wlast;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic [3:0]  s_axi_bid;
  logic        s_axi_bvalid;
  logic        s_axi_bready;

  always #5 clk = ~clk;

  axi_ram_slave dut (
    .s_aclk        (clk),
    .s_aresetn     (rst_n),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arlen   (s_axi_arlen),
    .s_axi_arsize  (s_axi_arsize),
    .s_axi_arburst (s_axi_arburst),
    .s_axi_arid    (s_axi_arid),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rid     (s_axi_rid),
    .s_axi_rlast   (s_axi_rlast),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awlen   (s_axi_awlen),
    .s_axi_awsize  (s_axi_awsize),
    .s_axi_awburst (s_axi_awburst),
    .s_axi_awid    (s_axi_awid),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wlast   (s_axi_wlast),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bid     (s_axi_bid),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready)
  );

  int n_chk = 0;
  int n_pass = 0;

  logic [31:0] wd [16];
  logic [31:0] rd [16];
  logic [1:0]  rr [16];
  logic [3:0]  ri [16];
  logic        rl [16];
  logic [1:0]  b_resp;
  logic [3:0]  b_id;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [3:0] id,
                           input logic [3:0] strb, input bit bad_last);
    int n;
    s_axi_awaddr  = addr;
    s_axi_awlen   = len;
    s_axi_awsize  = 3'd2;
    s_axi_awburst = burst;
    s_axi_awid    = id;
    s_axi_awvalid = 1'b1;
    n = 0;
    while (!s_axi_awready && n < 20) begin step(); n++; end
    check("aw_ready", 32'(s_axi_awready), 1);
    step();
    s_axi_awvalid = 1'b0;
    check("w_ready_rise", 32'(s_axi_wready), 1);
    for (int i = 0; i <= int'(len); i++) begin
      s_axi_wdata  = wd[i];
      s_axi_wstrb  = strb;
      s_axi_wlast  = bad_last ? 1'b0 : (i == int'(len));
      s_axi_wvalid = 1'b1;
      n = 0;
      while (!s_axi_wready && n < 20) begin step(); n++; end
      check("w_ready", 32'(s_axi_wready), 1);
      step();
    end
    s_axi_wvalid = 1'b0;
    s_axi_wlast  = 1'b0;
    check("b_valid_rise", 32'(s_axi_bvalid), 1);
    n = 0;
    while (!s_axi_bvalid && n < 20) begin step(); n++; end
    b_resp = s_axi_bresp;
    b_id   = s_axi_bid;
    s_axi_bready = 1'b1;
    step();
    s_axi_bready = 1'b0;
    check("aw_reassert", 32'(s_axi_awready), 1);
    check("b_drop", 32'(s_axi_bvalid), 0);
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [3:0] id,
                          input bit toggle);
    int n, k, cyc;
    bit stalled;
    logic [31:0] sd;
    logic [3:0]  si;
    s_axi_araddr  = addr;
    s_axi_arlen   = len;
    s_axi_arsize  = 3'd2;
    s_axi_arburst = burst;
    s_axi_arid    = id;
    s_axi_arvalid = 1'b1;
    n = 0;
    while (!s_axi_arready && n < 20) begin step(); n++; end
    check("ar_ready", 32'(s_axi_arready), 1);
    step();
    s_axi_arvalid = 1'b0;
    check("r_latency", 32'(s_axi_rvalid), 1);
    k = 0;
    cyc = 0;
    stalled = 0;
    sd = '0;
    si = '0;
    while (k <= int'(len) && cyc < 64) begin
      if (stalled) begin
        check("r_hold_data", s_axi_rdata, sd);
        check("r_hold_id", 32'(s_axi_rid), 32'(si));
      end
      s_axi_rready = toggle ? ((cyc % 2) == 0) : 1'b1;
      check("ar_busy", 32'(s_axi_arready), 0);
      stalled = 0;
      if (s_axi_rvalid && s_axi_rready) begin
        rd[k] = s_axi_rdata;
        rr[k] = s_axi_rresp;
        ri[k] = s_axi_rid;
        rl[k] = s_axi_rlast;
        k++;
      end else if (s_axi_rvalid) begin
        stalled = 1;
        sd = s_axi_rdata;
        si = s_axi_rid;
      end
      step();
      cyc++;
    end
    s_axi_rready = 1'b0;
    check("r_beats", k, 32'(len) + 1);
    check("ar_reassert", 32'(s_axi_arready), 1);
    check("r_drop", 32'(s_axi_rvalid), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0;
    s_axi_arburst = '0; s_axi_arid = '0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0;
    s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0;
    s_axi_awburst = '0; s_axi_awid = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    check("rst_arready", 32'(s_axi_arready), 1);
    check("rst_awready", 32'(s_axi_awready), 1);
    check("rst_rvalid", 32'(s_axi_rvalid), 0);
    check("rst_rlast", 32'(s_axi_rlast), 0);
    check("rst_rdata", s_axi_rdata, 0);
    check("rst_rresp", 32'(s_axi_rresp), 0);
    check("rst_rid", 32'(s_axi_rid), 0);
    check("rst_wready", 32'(s_axi_wready), 0);
    check("rst_bvalid", 32'(s_axi_bvalid), 0);
    check("rst_bresp", 32'(s_axi_bresp), 0);
    check("rst_bid", 32'(s_axi_bid), 0);
    rst_n = 1'b1;
    step();

    // basic INCR write then read back
    wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
    axi_write(BASE, 8'd3, 2'b01, 4'd5, 4'hF, 0);
    check("t1_bresp", 32'(b_resp), 0);
    check("t1_bid", 32'(b_id), 5);
    axi_read(BASE, 8'd3, 2'b01, 4'd9, 0);
    for (int i = 0; i < 4; i++) begin
      check("t1_rdata", rd[i], 32'h11 * (i + 1));
      check("t1_rresp", 32'(rr[i]), 0);
      check("t1_rid", 32'(ri[i]), 9);
      check("t1_rlast", 32'(rl[i]), 32'(i == 3));
    end

    // partial strobe merge
    wd[0] = 32'hAABB_CCDD;
    axi_write(BASE + 32'h10, 8'd0, 2'b01, 4'd1, 4'hF, 0);
    wd[0] = 32'h0000_1100;
    axi_write(BASE + 32'h10, 8'd0, 2'b01, 4'd1, 4'b0010, 0);
    axi_read(BASE + 32'h10, 8'd0, 2'b01, 4'd2, 0);
    check("t2_strobe", rd[0], 32'hAABB_11DD);

    // stalled len=7 read
    for (int i = 0; i < 8; i++) wd[i] = 32'h1000 + i;
    axi_write(BASE + 32'h100, 8'd7, 2'b01, 4'd7, 4'hF, 0);
    axi_read(BASE + 32'h100, 8'd7, 2'b01, 4'd6, 1);
    for (int i = 0; i < 8; i++) begin
      check("t3_rdata", rd[i], 32'h1000 + i);
      check("t3_rid", 32'(ri[i]), 6);
      check("t3_rlast", 32'(rl[i]), 32'(i == 7));
    end

    // out of range: error response, no aliasing into word 0
    wd[0] = 32'hDEAD_BEEF;
    axi_write(BASE + 32'h0004_0000, 8'd0, 2'b01, 4'd4, 4'hF, 0);
    check("t4_bresp", 32'(b_resp), 2);
    axi_read(BASE, 8'd0, 2'b01, 4'd0, 0);
    check("t4_ram_kept", rd[0], 32'h11);
    axi_read(BASE + 32'h0004_0000, 8'd0, 2'b01, 4'd3, 0);
    check("t4_rdata", rd[0], 0);
    check("t4_rresp", 32'(rr[0]), 2);
    axi_read(BASE - 32'h4, 8'd0, 2'b01, 4'd3, 0);
    check("t4_below", 32'(rr[0]), 2);

    // wlast mismatch flags an error
    wd[0] = 32'h1; wd[1] = 32'h2;
    axi_write(BASE + 32'h80, 8'd1, 2'b01, 4'd8, 4'hF, 1);
    check("t5_wlast_err", 32'(b_resp), 2);

    // FIXED bursts stay on one word
    wd[0] = 32'h1; wd[1] = 32'h2; wd[2] = 32'h3;
    axi_write(BASE + 32'h40, 8'd2, 2'b00, 4'd2, 4'hF, 0);
    check("t6_bresp", 32'(b_resp), 0);
    axi_read(BASE + 32'h40, 8'd1, 2'b00, 4'd2, 0);
    check("t6_fixed0", rd[0], 3);
    check("t6_fixed1", rd[1], 3);
    axi_read(BASE + 32'h44, 8'd0, 2'b01, 4'd2, 0);
    check("t6_next_word", rd[0], 0);

    // WRAP bursts
    for (int i = 0; i < 6; i++) wd[i] = 32'h5020 + 4 * i;
    axi_write(BASE + 32'h20, 8'd5, 2'b01, 4'd1, 4'hF, 0);
    axi_read(BASE + 32'h28, 8'd3, 2'b10, 4'd1, 0);
`ifdef AXI_RAM_WRAP_EN
    check("t7_w0", rd[0], 32'h5028);
    check("t7_w1", rd[1], 32'h502C);
    check("t7_w2", rd[2], 32'h5020);
    check("t7_w3", rd[3], 32'h5024);
`else
    check("t7_w0", rd[0], 32'h5028);
    check("t7_w1", rd[1], 32'h502C);
    check("t7_w2", rd[2], 32'h5030);
    check("t7_w3", rd[3], 32'h5034);
`endif
    for (int i = 0; i < 4; i++) check("t7_rresp", 32'(rr[i]), 0);
    axi_read(BASE + 32'h28, 8'd2, 2'b10, 4'd1, 0);
`ifdef AXI_RAM_WRAP_EN
    for (int i = 0; i < 3; i++) begin
      check("t7_bad_resp", 32'(rr[i]), 2);
      check("t7_bad_data", rd[i], 0);
    end
`else
    for (int i = 0; i < 3; i++) begin
      check("t7_len2_resp", 32'(rr[i]), 0);
      check("t7_len2_data", rd[i], 32'h5028 + 4 * i);
    end
`endif

    // reset asserted during beat 2 of a len=7 write
    s_axi_awaddr = BASE + 32'h200; s_axi_awlen = 8'd7;
    s_axi_awsize = 3'd2; s_axi_awburst = 2'b01; s_axi_awid = 4'd9;
    s_axi_awvalid = 1'b1;
    step();
    s_axi_awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_axi_wdata = 32'h7700 + i; s_axi_wstrb = 4'hF;
      s_axi_wlast = 1'b0; s_axi_wvalid = 1'b1;
      step();
    end
    check("t8_mid_wready", 32'(s_axi_wready), 1);
    rst_n = 1'b0;
    #1;
    check("t8_rst_wready", 32'(s_axi_wready), 0);
    check("t8_rst_bvalid", 32'(s_axi_bvalid), 0);
    check("t8_rst_awready", 32'(s_axi_awready), 1);
    s_axi_wvalid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    check("t8_post_awready", 32'(s_axi_awready), 1);
    check("t8_post_bvalid", 32'(s_axi_bvalid), 0);
    wd[0] = 32'hCAFE;
    axi_write(BASE + 32'h200, 8'd0, 2'b01, 4'd3, 4'hF, 0);
    check("t8_bresp", 32'(b_resp), 0);
    check("t8_bid", 32'(b_id), 3);
    axi_read(BASE + 32'h200, 8'd0, 2'b01, 4'd3, 0);
    check("t8_rdata", rd[0], 32'hCAFE);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
